serial_subtractor: RTL and testbench
====================================

# serial_subtractor

Bit-serial two's-complement subtractor computing `a - b` one bit per cycle, LSB first, with a borrow chain held in a flop. It is the inverse-direction companion to the combinational ripple-carry adder in the datapath. It produces `{bout, diff}` in the same layout as the adder's `{cout, sum}`, so both can be checked against each other on the same operands. It trades latency for area: one 1-bit full-subtractor cell is reused PROC_SIZE times.

## Interface
- PROC_SIZE, 16, operand/result width in bits; legal values are ≥2.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands are presented.
- in_ready  output  1  block accepts operands; high only in IDLE.
- a  input  PROC_SIZE  minuend.
- b  input  PROC_SIZE  subtrahend.
- out_valid  output  1  result is valid; high only in DONE.
- out_ready  input  1  consumer takes the result.
- diff  output  PROC_SIZE  `a - b` mod 2^PROC_SIZE.
- bout  output  1  borrow out; 1 iff `a < b` unsigned.
- ovf  output  1  signed overflow; present only with SERSUB_OVF_EN.

## Operation
- **FSM states:** IDLE, RUN, DONE.
- **IDLE:**
  - in_ready=1.
  - On in_valid: latch a and b into shift registers, clear borrow and bit counter, go to RUN.
- **RUN:** each cycle, with a0/b0 the current LSBs and br the borrow flop:
  - d = a0^b0^br
  - br_next = (~a0&b0) | (~(a0^b0)&br)
  - Shift d into the MSB of the diff shift register, shift a/b right by one, increment the counter.
  - After the PROC_SIZE-th bit, go to DONE with bout = final borrow.
  - in_valid, a and b are ignored in RUN.
- **DONE:**
  - out_valid=1; diff, bout (and ovf) are stable.
  - On out_ready: go to IDLE.
  - Without out_ready: hold indefinitely, with outputs unchanged.
- **Arithmetic:** unsigned; diff wraps modulo 2^PROC_SIZE; no sign extension.
- **Bit counter:** width $clog2(PROC_SIZE)+1; never wraps within an operation.

## Timing
- **Reset values:** state=IDLE, in_ready=1, out_valid=0, diff=0, bout=0, ovf=0, counter=0, borrow=0.
- **Latency:** operands accepted at edge k (in_valid & in_ready); out_valid rises after edge k+PROC_SIZE (PROC_SIZE cycles of RUN).
- **Handshakes:**
  - Input handshake completes on a single edge.
  - Output handshake: result is retired on the edge where out_valid & out_ready.
  - in_ready goes high the following cycle.
  - Minimum initiation interval is PROC_SIZE+2 cycles, with out_ready tied high.
- **Simultaneous events:**
  - in_valid asserted while in DONE is not accepted; it must be held until in_ready.
  - rst has priority over every handshake.
- **Reset mid-operation:** rst in RUN or DONE returns to IDLE on the next edge. The in-flight result is discarded and out_valid is never pulsed for it.
- diff/bout are registered outputs. They may change only on entry to DONE or on reset.

## Configuration
- **SERSUB_OVF_EN defined:**
  - The ovf port and logic exist.
  - On entry to DONE, ovf = (a[MSB]≠b[MSB]) & (diff[MSB]≠a[MSB]), using the latched original a/b MSBs.
- **SERSUB_OVF_EN undefined:**
  - The ovf port is absent.
  - No sign-bit capture flops are instantiated.

## Structure
- **Package serial_subtractor_pkg:**
  - FSM state enum (IDLE, RUN, DONE).
  - Default PROC_SIZE constant.
  - Counter-width function/constant.
- **Sub-module full_subtractor:**
  - Combinational 1-bit cell (inputs a, b, bin; outputs d, bout).
  - Instantiated once in the top.

## Test plan
- Reset, then a=0, b=0 -> after 16 RUN cycles: out_valid=1, diff=0, bout=0.
- a=2, b=1 -> diff=1, bout=0. Then a=1, b=2 -> diff=16'hFFFF, bout=1.
- a=15, b=15, with out_ready held low 5 cycles -> DONE held, diff=0, bout=0 stable; in_ready=0 throughout; retires on out_ready.
- a=16'h8000, b=1 -> diff=16'h7FFF, bout=0, ovf=1 (SERSUB_OVF_EN); ovf absent when not defined.
- in_valid toggled with new operands during RUN -> ignored; result matches the first operands.
- rst pulsed at RUN cycle 7 -> next edge IDLE, in_ready=1, out_valid never asserted. A new a=9, b=10 then gives diff=16'hFFFF, bout=1.

Source files
------------

// File: rtl/serial_subtractor_pkg.sv
// Shared types and constants for the bit-serial subtractor.
// Optional signed-overflow flag is enabled with SERSUB_OVF_EN.
package serial_subtractor_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_PROC_SIZE = 16;

    // One extra bit so the count can reach the width without wrapping.
    function automatic int cnt_width(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full-subtractor cell, reused every cycle by the serial core.
// Computes a - b - bin with borrow out.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b, LSB first, borrow kept in a flop between cycles.
// Define SERSUB_OVF_EN to add the ovf port and sign-bit capture.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int PROC_SIZE = DEF_PROC_SIZE
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PROC_SIZE-1:0] a,
    input  logic [PROC_SIZE-1:0] b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PROC_SIZE-1:0] diff,
    output logic                 bout
`ifdef SERSUB_OVF_EN
    ,
    output logic                 ovf
`endif
);

    localparam int CW = cnt_width(PROC_SIZE);
    localparam logic [CW-1:0] LAST_BIT = CW'(PROC_SIZE - 1);

    state_t state;
    state_t state_n;

    logic start;
    logic step;
    logic last;

    logic [PROC_SIZE-1:0] a_sh;
    logic [PROC_SIZE-1:0] b_sh;
    logic [PROC_SIZE-1:0] d_sh;
    logic [PROC_SIZE-1:0] d_final;
    logic [CW-1:0]        cnt;
    logic                 br;
    logic                 d_bit;
    logic                 br_n;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        start   = 1'b0;
        step    = 1'b0;
        last    = 1'b0;
        unique case (state)
            IDLE: begin
                if (in_valid) begin
                    start   = 1'b1;
                    state_n = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (cnt == LAST_BIT) begin
                    last    = 1'b1;
                    state_n = DONE;
                end
            end
            DONE: begin
                if (out_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    full_subtractor u_fs (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .bin  (br),
        .d    (d_bit),
        .bout (br_n)
    );

    // The last bit lands in the MSB; publish it without waiting a cycle.
    assign d_final = {d_bit, d_sh[PROC_SIZE-1:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh <= '0;
            b_sh <= '0;
            d_sh <= '0;
            br   <= 1'b0;
            cnt  <= '0;
            diff <= '0;
            bout <= 1'b0;
        end else begin
            if (start) begin
                a_sh <= a;
                b_sh <= b;
                br   <= 1'b0;
                cnt  <= '0;
            end
            if (step) begin
                a_sh <= a_sh >> 1;
                b_sh <= b_sh >> 1;
                d_sh <= d_final;
                br   <= br_n;
                cnt  <= cnt + CW'(1);
            end
            if (last) begin
                diff <= d_final;
                bout <= br_n;
            end
        end
    end

`ifdef SERSUB_OVF_EN
    logic a_msb;
    logic b_msb;

    always_ff @(posedge clk) begin
        if (rst) begin
            a_msb <= 1'b0;
            b_msb <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            if (start) begin
                a_msb <= a[PROC_SIZE-1];
                b_msb <= b[PROC_SIZE-1];
            end
            if (last) ovf <= (a_msb ^ b_msb) & (d_bit ^ a_msb);
        end
    end
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and random checks of serial_subtractor against an arithmetic model.
// Build with SERSUB_OVF_EN to also check the overflow flag.
module tb_serial_subtractor;

    localparam int PS = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [PS-1:0] a;
    logic [PS-1:0] b;
    logic          out_valid;
    logic          out_ready;
    logic [PS-1:0] diff;
    logic          bout;
`ifdef SERSUB_OVF_EN
    logic          ovf;
`endif

    int checks   = 0;
    int failures = 0;
    logic [PS-1:0] prev_diff;
    logic          prev_bout;

    always #5 clk = ~clk;

    serial_subtractor #(.PROC_SIZE(PS)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout)
`ifdef SERSUB_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one operation, check latency and result, hold DONE, retire.
    task automatic run_op(input logic [PS-1:0] ta, input logic [PS-1:0] tb_,
                          input int hold, input bit poke);
        int n;
        int sa;
        int sb;
        int r;
        logic [PS-1:0] e_diff;
        logic          e_bout;
        logic          e_ovf;

        e_diff = PS'(int'(ta) - int'(tb_));
        e_bout = (ta < tb_);
        sa     = int'($signed(ta));
        sb     = int'($signed(tb_));
        r      = sa - sb;
        e_ovf  = (r > 32767) || (r < -32768);

        @(negedge clk);
        check("accept_ready", 32'(in_ready), 32'd1);
        a        = ta;
        b        = tb_;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 40) begin
            check("run_in_ready", 32'(in_ready), 32'd0);
            check("run_diff_hold", 32'(diff), 32'(prev_diff));
            check("run_bout_hold", 32'(bout), 32'(prev_bout));
            if (poke) begin
                in_valid = 1'b1;
                a        = PS'($urandom);
                b        = PS'($urandom);
            end
            @(negedge clk);
            n++;
        end
        in_valid = 1'b0;
        check("latency", 32'(n), 32'(PS));
        check("diff", 32'(diff), 32'(e_diff));
        check("bout", 32'(bout), 32'(e_bout));
`ifdef SERSUB_OVF_EN
        check("ovf", 32'(ovf), 32'(e_ovf));
`endif
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_ready", 32'(in_ready), 32'd0);
            check("hold_diff", 32'(diff), 32'(e_diff));
            check("hold_bout", 32'(bout), 32'(e_bout));
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("retire_valid", 32'(out_valid), 32'd0);
        check("retire_ready", 32'(in_ready), 32'd1);
        check("retire_diff", 32'(diff), 32'(e_diff));
        prev_diff = e_diff;
        prev_bout = e_bout;
    endtask

    initial begin
        int n;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        prev_diff = '0;
        prev_bout = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_diff", 32'(diff), 32'd0);
        check("rst_bout", 32'(bout), 32'd0);
`ifdef SERSUB_OVF_EN
        check("rst_ovf", 32'(ovf), 32'd0);
`endif
        rst = 1'b0;

        run_op(16'd0, 16'd0, 0, 1'b0);
        run_op(16'd2, 16'd1, 0, 1'b0);
        run_op(16'd1, 16'd2, 0, 1'b0);
        run_op(16'd15, 16'd15, 5, 1'b0);
        run_op(16'h8000, 16'd1, 1, 1'b0);
        run_op(16'h7FFF, 16'hFFFF, 0, 1'b0);
        run_op(16'hFFFF, 16'h0001, 0, 1'b0);
        run_op(16'h1234, 16'h0FED, 0, 1'b1);

        for (int k = 0; k < 20; k++)
            run_op(PS'($urandom), PS'($urandom), int'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)));

        // Reset in the middle of RUN: the result must never appear.
        @(negedge clk);
        a        = 16'h5555;
        b        = 16'h1111;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_diff", 32'(diff), 32'd0);
        check("midrst_bout", 32'(bout), 32'd0);
        n = 0;
        for (int i = 0; i < PS + 4; i++) begin
            @(negedge clk);
            if (out_valid) n++;
        end
        check("midrst_no_valid", 32'(n), 32'd0);
        prev_diff = '0;
        prev_bout = 1'b0;
        run_op(16'd9, 16'd10, 0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
